shared_reg_arbiter: RTL and testbench



---
 rtl/shared_reg_arbiter.sv | 152 +++++++++++++++
 tb/tb_shared_reg_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/shared_reg_arbiter.sv
// Two-requester round-robin arbiter granting exclusive write ownership of one shared output register.
// Optional SHARED_REG_ARB_BURST_LIMIT_EN caps consecutive transfers at BURST while the other side waits.
module shared_reg_arbiter #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [WIDTH-1:0] z,
  output logic             z_valid,
  output logic             owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  if (BURST < 1) begin : g_burst_check
    $error("shared_reg_arbiter: BURST must be >= 1");
  end

  state_t           state_q, state_d;
  logic             last_q, last_d;      // 0 = A owned most recently, 1 = B
  logic [WIDTH-1:0] z_q, z_d;
  logic             z_valid_q, z_valid_d;
  logic             owner_q, owner_d;
  logic             xfer_a, xfer_b;

`ifdef SHARED_REG_ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          burst_done;
`endif

  assign xfer_a = (state_q == OWN_A) && req_a;
  assign xfer_b = (state_q == OWN_B) && req_b;

`ifdef SHARED_REG_ARB_BURST_LIMIT_EN
  // Saturating increment; a saturated counter still counts as "reaching" BURST.
  assign cnt_inc    = (cnt_q == BURST_C) ? cnt_q : cnt_q + CW'(1);
  assign burst_done = (cnt_inc == BURST_C);
`endif

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    z_d       = z_q;
    z_valid_d = 1'b0;
    owner_d   = owner_q;

    if (xfer_a) begin
      z_d       = data_a;
      owner_d   = 1'b0;
      z_valid_d = 1'b1;
    end else if (xfer_b) begin
      z_d       = data_b;
      owner_d   = 1'b1;
      z_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (req_a && (!req_b || last_q)) begin
          state_d = OWN_A;
        end else if (req_b) begin
          state_d = OWN_B;
        end
      end
      OWN_A: begin
        if (!req_a) begin
          state_d = req_b ? OWN_B : IDLE;
        end
`ifdef SHARED_REG_ARB_BURST_LIMIT_EN
        else if (burst_done && req_b) begin
          state_d = OWN_B;
        end
`endif
      end
      OWN_B: begin
        if (!req_b) begin
          state_d = req_a ? OWN_A : IDLE;
        end
`ifdef SHARED_REG_ARB_BURST_LIMIT_EN
        else if (burst_done && req_a) begin
          state_d = OWN_A;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      if (state_d == OWN_A) begin
        last_d = 1'b0;
      end else if (state_d == OWN_B) begin
        last_d = 1'b1;
      end
    end
  end

`ifdef SHARED_REG_ARB_BURST_LIMIT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (xfer_a || xfer_b) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      z_q       <= '0;
      z_valid_q <= 1'b0;
      owner_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      z_q       <= z_d;
      z_valid_q <= z_valid_d;
      owner_q   <= owner_d;
    end
  end

  assign gnt_a   = (state_q == OWN_A);
  assign gnt_b   = (state_q == OWN_B);
  assign z       = z_q;
  assign z_valid = z_valid_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter (WIDTH=8, BURST=4).
// Expectations follow SHARED_REG_ARB_BURST_LIMIT_EN when the bench is built with it.
module tb_shared_reg_arbiter;

`ifdef SHARED_REG_ARB_BURST_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       req_a, req_b;
  logic [7:0] data_a, data_b;
  logic       gnt_a, gnt_b;
  logic [7:0] z;
  logic       z_valid;
  logic       owner;

  int n_tests = 0;
  int n_fail  = 0;

  shared_reg_arbiter #(.WIDTH(8), .BURST(4)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_a  (req_a),
    .data_a (data_a),
    .req_b  (req_b),
    .data_b (data_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .z      (z),
    .z_valid(z_valid),
    .owner  (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ga, input logic gb, input logic zv,
                           input logic [7:0] zz, input logic own);
    check_eq({tag, ".gnt_a"},   32'(gnt_a),   32'(ga));
    check_eq({tag, ".gnt_b"},   32'(gnt_b),   32'(gb));
    check_eq({tag, ".z_valid"}, 32'(z_valid), 32'(zv));
    check_eq({tag, ".z"},       32'(z),       32'(zz));
    check_eq({tag, ".owner"},   32'(owner),   32'(own));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_eq("gnt_mutex", 32'(gnt_a & gnt_b), 32'd0);
  endtask

  // Pulses reset away from any clock edge and releases it on the falling edge.
  task automatic do_reset(input logic ra, input logic rb);
    #2;
    rst_n = 1'b0;
    req_a = ra;
    req_b = rb;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] own_vec;
    logic [11:0] ga_vec;
    logic        ob;

    rst_n  = 1'b1;
    req_a  = 1'b0;
    req_b  = 1'b0;
    data_a = 8'h00;
    data_b = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    check_out("reset", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, then asynchronous reset mid-transfer.
    req_a  = 1'b1;
    data_a = 8'h11;
    step();
    check_out("single.grant", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    check_out("single.x11", 1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
    data_a = 8'h22;
    step();
    check_out("single.x22", 1'b1, 1'b0, 1'b1, 8'h22, 1'b0);
    data_a = 8'h33;
    step();
    check_out("single.x33", 1'b1, 1'b0, 1'b1, 8'h33, 1'b0);
    data_a = 8'h5A;
    step();
    check_out("single.x5a", 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0);
    #2;
    rst_n = 1'b0;
    req_a = 1'b0;
    #1;
    check_out("async_reset", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);

    // Simultaneous requests held from reset release.
    req_a  = 1'b1;
    req_b  = 1'b1;
    rst_n  = 1'b1;
    step();
    check_out("simul.grant", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    own_vec = LIMIT_EN ? 12'b0000_1111_0000 : 12'b0000_0000_0000;
    ga_vec  = LIMIT_EN ? 12'b1110_0001_1110 : 12'b1111_1111_1111;
    for (int k = 1; k <= 12; k++) begin
      data_a = 8'(8'hA0 + k);
      data_b = 8'(8'hB0 + k);
      step();
      ob = own_vec[12-k];
      check_out($sformatf("simul.k%0d", k), ga_vec[12-k], ~ga_vec[12-k], 1'b1,
                ob ? 8'(8'hB0 + k) : 8'(8'hA0 + k), ob);
    end
    req_a  = 1'b0;
    data_b = 8'hEE;
    step();
    check_eq("simul.drop.gnt_b", 32'(gnt_b), 32'd1);
    check_eq("simul.drop.z_valid", 32'(z_valid), 32'(LIMIT_EN));
    step();
    check_out("simul.b_after", 1'b0, 1'b1, 1'b1, 8'hEE, 1'b1);

    // Voluntary handoff after two transfers of A.
    do_reset(1'b0, 1'b0);
    req_a  = 1'b1;
    data_a = 8'h31;
    step();
    check_out("handoff.grant", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    check_out("handoff.x31", 1'b1, 1'b0, 1'b1, 8'h31, 1'b0);
    data_a = 8'h32;
    req_b  = 1'b1;
    data_b = 8'hC1;
    step();
    check_out("handoff.x32", 1'b1, 1'b0, 1'b1, 8'h32, 1'b0);
    req_a  = 1'b0;
    data_a = 8'hFF;
    step();
    check_out("handoff.bubble", 1'b0, 1'b1, 1'b0, 8'h32, 1'b0);
    step();
    check_out("handoff.xc1", 1'b0, 1'b1, 1'b1, 8'hC1, 1'b1);
    req_b = 1'b0;
    step();
    check_out("handoff.idle", 1'b0, 1'b0, 1'b0, 8'hC1, 1'b1);

    // No contention: A keeps the grant through ten transfers.
    do_reset(1'b1, 1'b0);
    data_a = 8'h40;
    step();
    check_out("nocont.grant", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      data_a = 8'(8'h40 + i);
      step();
      check_out($sformatf("nocont.t%0d", i), 1'b1, 1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    end
    req_b  = 1'b1;
    data_b = 8'hD0;
    data_a = 8'h4B;
    step();
    check_out("nocont.late_b", ~LIMIT_EN, LIMIT_EN, 1'b1, 8'h4B, 1'b0);

    // Round robin after A was last owner: B wins contention from IDLE.
    do_reset(1'b1, 1'b0);
    data_a = 8'h61;
    step();
    step();
    check_out("rr.x61", 1'b1, 1'b0, 1'b1, 8'h61, 1'b0);
    req_a  = 1'b0;
    data_a = 8'h99;
    step();
    check_out("rr.idle", 1'b0, 1'b0, 1'b0, 8'h61, 1'b0);
    req_a  = 1'b1;
    req_b  = 1'b1;
    data_b = 8'h62;
    step();
    check_out("rr.grant_b", 1'b0, 1'b1, 1'b0, 8'h61, 1'b0);
    step();
    check_out("rr.x62", 1'b0, 1'b1, 1'b1, 8'h62, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
